// File: rtl/line_mem_pkg.sv
// Shared types and constants for the beat-serial main-memory responder.
package line_mem_pkg;

  localparam int unsigned DEFAULT_LINE_ADDR_W = 13;
  localparam int unsigned WORDS_PER_LINE      = 16;
  localparam int unsigned BEAT_IDX_W          = $clog2(WORDS_PER_LINE);

  typedef logic [DEFAULT_LINE_ADDR_W-1:0] line_addr_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RBURST,
    WBURST,
    WACK
  } line_mem_state_t;

endpackage

// File: rtl/line_mem_array.sv
// Line-organised word storage: one asynchronous read port, one synchronous write port.
// Contents survive reset; line i word 0 reads back as i until written.
module line_mem_array #(
  parameter int unsigned LINE_ADDR_W    = 13,
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned WORDS_PER_LINE = 16
) (
  input  logic                              clk,
  input  logic                              we,
  input  logic [LINE_ADDR_W-1:0]            waddr,
  input  logic [$clog2(WORDS_PER_LINE)-1:0] widx,
  input  logic [WORD_W-1:0]                 wdata,
  input  logic [LINE_ADDR_W-1:0]            raddr,
  input  logic [$clog2(WORDS_PER_LINE)-1:0] ridx,
  output logic [WORD_W-1:0]                 rdata
);
  import line_mem_pkg::*;

  localparam int unsigned IDX_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned DEPTH = 2 ** (LINE_ADDR_W + IDX_W);

  // Words are stored XORed with their power-up value, so an all-zero array
  // represents the preloaded image without any per-entry initialisation.
  logic [WORD_W-1:0] mem [DEPTH] = '{default: '0};

  function automatic logic [WORD_W-1:0] preload(input logic [LINE_ADDR_W-1:0] line,
                                                input logic [IDX_W-1:0]       idx);
    return (idx == '0) ? WORD_W'(line) : '0;
  endfunction

  always_ff @(posedge clk) begin
    if (we) mem[{waddr, widx}] <= wdata ^ preload(waddr, widx);
  end

  assign rdata = mem[{raddr, ridx}] ^ preload(raddr, ridx);

endmodule

// File: rtl/line_mem_responder.sv
// Main-memory model serving 16-beat line fills and writebacks with programmable latency.
// Optional: LINE_MEM_CRIT_WORD_FIRST_EN starts read bursts at req_word (critical word first).
module line_mem_responder #(
  parameter int unsigned LINE_ADDR_W    = 13,
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned WORDS_PER_LINE = 16,
  parameter int unsigned LATENCY        = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [LINE_ADDR_W-1:0] req_line_addr,
  input  logic [3:0]             req_word,
  input  logic                   wdata_valid,
  input  logic [WORD_W-1:0]      wdata,
  output logic                   wdata_ready,
  output logic                   rdata_valid,
  output logic [WORD_W-1:0]      rdata,
  output logic                   rdata_last,
  input  logic                   rdata_ready,
  output logic                   wr_ack
);
  import line_mem_pkg::*;

  localparam int unsigned IDX_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(LATENCY - 1);

  line_mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       beat_q, beat_d;
  logic [LINE_ADDR_W-1:0] line_q, line_d;
  logic                   write_q, write_d;
  logic [IDX_W-1:0]       start_idx;
  logic [WORD_W-1:0]      arr_rdata;
  logic                   mem_we;
  logic                   beat_last;

`ifdef LINE_MEM_CRIT_WORD_FIRST_EN
  assign start_idx = IDX_W'(req_word);
`else
  logic [3:0] unused_req_word;
  assign unused_req_word = req_word;
  assign start_idx       = '0;
`endif

  // beat_q counts transfers, independent of where idx_q started the wrap
  assign beat_last = (beat_q == IDX_W'(WORDS_PER_LINE - 1));
  assign mem_we    = (state_q == WBURST) && wdata_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      beat_q  <= '0;
      line_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    beat_d      = beat_q;
    line_d      = line_q;
    write_d     = write_q;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    rdata       = '0;
    rdata_last  = 1'b0;
    wr_ack      = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d = req_write;
          line_d  = req_line_addr;
          idx_d   = req_write ? '0 : start_idx;
          beat_d  = '0;
          cnt_d   = CNT_START;
          if (LATENCY > 0) state_d = WAIT;
          else             state_d = req_write ? WBURST : RBURST;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = write_q ? WBURST : RBURST;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RBURST: begin
        rdata_valid = 1'b1;
        rdata       = arr_rdata;
        rdata_last  = beat_last;
        if (rdata_ready) begin
          idx_d  = idx_q + 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_last) state_d = IDLE;
        end
      end
      WBURST: begin
        wdata_ready = 1'b1;
        if (wdata_valid) begin
          idx_d  = idx_q + 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_last) state_d = WACK;
        end
      end
      WACK: begin
        wr_ack  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  line_mem_array #(
    .LINE_ADDR_W   (LINE_ADDR_W),
    .WORD_W        (WORD_W),
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(line_q),
    .widx (idx_q),
    .wdata(wdata),
    .raddr(line_q),
    .ridx (idx_q),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench for line_mem_responder: directed fills/writebacks, a LATENCY=4 and a LATENCY=0 instance.
module tb_line_mem_responder;
  import line_mem_pkg::*;

  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  line_addr_t  req_line_addr;
  logic [3:0]  req_word;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata, rdata;
  logic        rdata_valid, rdata_last, rdata_ready, wr_ack;

  logic        z_req_valid, z_req_ready, z_req_write;
  line_addr_t  z_req_line_addr;
  logic [3:0]  z_req_word;
  logic        z_wdata_valid, z_wdata_ready;
  logic [31:0] z_wdata, z_rdata;
  logic        z_rdata_valid, z_rdata_last, z_rdata_ready, z_wr_ack;

  line_mem_responder #(.LINE_ADDR_W(13), .WORD_W(32), .WORDS_PER_LINE(16), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_line_addr(req_line_addr), .req_word(req_word),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
    .rdata_ready(rdata_ready), .wr_ack(wr_ack)
  );

  line_mem_responder #(.LINE_ADDR_W(13), .WORD_W(32), .WORDS_PER_LINE(16), .LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_write(z_req_write), .req_line_addr(z_req_line_addr), .req_word(z_req_word),
    .wdata_valid(z_wdata_valid), .wdata(z_wdata), .wdata_ready(z_wdata_ready),
    .rdata_valid(z_rdata_valid), .rdata(z_rdata), .rdata_last(z_rdata_last),
    .rdata_ready(z_rdata_ready), .wr_ack(z_wr_ack)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  int          errors = 0;
  int          checks = 0;
  beat_t       rq[$];
  beat_t       zq[$];
  int          ack_pending = 0;
  logic [31:0] model [int];

  function automatic logic [31:0] model_rd(int line, int w);
    if (model.exists(line * 16 + w)) return model[line * 16 + w];
    return (w == 0) ? 32'(line) : 32'd0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beat(bit zero_lat, logic [31:0] data, logic last);
    beat_t e;
    e.data = data;
    e.last = last;
    if (zero_lat) zq.push_back(e);
    else          rq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rdata_valid) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rbeat: got %0h expected none", rdata);
        end else begin
          chk("rdata", rdata, rq[0].data);
          chk("rdata_last", 32'(rdata_last), 32'(rq[0].last));
          if (rdata_ready) void'(rq.pop_front());
        end
      end
      if (wr_ack) begin
        checks++;
        if (ack_pending == 0) begin
          errors++;
          $display("FAIL unexpected_wr_ack: got 1 expected 0 at %0t", $time);
        end else ack_pending--;
      end
      if (z_rdata_valid) begin
        if (zq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_z_rbeat: got %0h expected none", z_rdata);
        end else begin
          chk("z_rdata", z_rdata, zq[0].data);
          chk("z_rdata_last", 32'(z_rdata_last), 32'(zq[0].last));
          if (z_rdata_ready) void'(zq.pop_front());
        end
      end
    end
  end

  task automatic fill(int line, int word, bit toggle);
    int start;
    int n;
`ifdef LINE_MEM_CRIT_WORD_FIRST_EN
    start = word;
`else
    start = 0;
`endif
    for (int b = 0; b < 16; b++) push_beat(1'b0, model_rd(line, (start + b) % 16), b == 15);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_write = 1'b0; req_line_addr = line_addr_t'(line); req_word = 4'(word); req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    while (!rdata_valid && n < 40) begin @(posedge clk); #1 n++; end
    chk("fill_latency", 32'(n), 32'(LAT));
    n = 0;
    while (rq.size() != 0 && n < 200) begin
      rdata_ready = toggle ? ~rdata_ready : 1'b1;
      @(posedge clk); #1 n++;
    end
    chk("fill_drained", 32'(rq.size()), 32'd0);
    chk("req_ready_after_fill", 32'(req_ready), 32'd1);
    chk("rvalid_after_fill", 32'(rdata_valid), 32'd0);
    rdata_ready = 1'b1;
    rq.delete();
  endtask

  task automatic writeback(int line, logic [31:0] base, bit gap, int abort_after);
    int sent;
    int c;
    int n;
    req_write = 1'b1; req_line_addr = line_addr_t'(line); req_word = 4'd0; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    while (!wdata_ready && n < 40) begin @(posedge clk); #1 n++; end
    chk("wb_latency", 32'(n), 32'(LAT));
    sent = 0;
    c = 0;
    while (sent < 16 && c < 200) begin
      if (abort_after >= 0 && sent == abort_after) break;
      wdata_valid = !(gap && (c % 3 == 2));
      wdata = base + 32'(sent);
      @(posedge clk);
      if (wdata_valid && wdata_ready) begin
        model[line * 16 + sent] = base + 32'(sent);
        sent++;
        if (sent == 16) ack_pending++;
      end
      #1 c++;
    end
    wdata_valid = 1'b0;
    if (abort_after >= 0) begin
      #1 rst_n = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_wdata_ready", 32'(wdata_ready), 32'd0);
      chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_wr_ack", 32'(wr_ack), 32'd0);
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("req_ready_after_release", 32'(req_ready), 32'd1);
    end else begin
      @(posedge clk); #1;
      chk("wr_ack_count", 32'(ack_pending), 32'd0);
      chk("req_ready_after_ack", 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_line_addr = '0; req_word = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b1;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_line_addr = '0; z_req_word = '0;
    z_wdata_valid = 1'b0; z_wdata = '0; z_rdata_ready = 1'b1;
    #12;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("reset_rdata_last", 32'(rdata_last), 32'd0);
    chk("reset_wdata_ready", 32'(wdata_ready), 32'd0);
    chk("reset_wr_ack", 32'(wr_ack), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    fill(8, 0, 1'b0);                         // 8, then fifteen zeros
    writeback(8, 32'd129, 1'b1, -1);          // 129..144, gapped every 3rd cycle
    fill(8, 0, 1'b0);                         // reads back 129..144
    fill(1024, 0, 1'b1);                      // 1024 then zeros, ready toggling
    writeback(3, 32'hA5A5_0000, 1'b0, 5);     // reset after beat 5
    fill(3, 0, 1'b0);                         // new words 0..4, original 5..15
    fill(8, 9, 1'b0);                         // critical-word start 9 when enabled

    for (int k = 0; k < 2; k++) begin
      int line;
      int n;
      line = (k == 0) ? 0 : 5;
      for (int b = 0; b < 16; b++) push_beat(1'b1, (b == 0) ? 32'(line) : 32'd0, b == 15);
      z_req_line_addr = line_addr_t'(line); z_req_valid = 1'b1;
      @(posedge clk); #1 z_req_valid = 1'b0;
      chk("lat0_first_valid", 32'(z_rdata_valid), 32'd1);
      n = 0;
      while (zq.size() != 0 && n < 100) begin @(posedge clk); #1 n++; end
      chk("lat0_drained", 32'(zq.size()), 32'd0);
      chk("lat0_req_ready", 32'(z_req_ready), 32'd1);
      zq.delete();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Backing main-memory model on the memory side of the direct-mapped write-back cache.
- Serves two request types from the cache controller over a valid/ready handshake:
  - line fills: 16-beat read bursts;
  - dirty-line writebacks: 16-beat write bursts.
- Adds a programmable access latency.
- Replaces the single-cycle whole-line array access with a realistic beat-serial memory port.

Parameters:
- LINE_ADDR_W, 13: line address width (8K lines).
- WORD_W, 32: beat and word width.
- WORDS_PER_LINE, 16: beats per burst; must be a power of two.
- LATENCY, 4: wait cycles between request acceptance and the first data beat or wdata_ready; 0 is legal.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: responder can accept a request.
- req_write, in, 1: 1 = writeback, 0 = line fill.
- req_line_addr, in, LINE_ADDR_W: line index ({tag, set}).
- req_word, in, 4: critical word index; used only with the optional feature.
- wdata_valid, in, 1: write beat present.
- wdata, in, WORD_W: write beat data.
- wdata_ready, out, 1: responder accepts write beats.
- rdata_valid, out, 1: read beat present.
- rdata, out, WORD_W: read beat data.
- rdata_last, out, 1: final beat of the read burst.
- rdata_ready, in, 1: cache accepts the read beat.
- wr_ack, out, 1: one-cycle pulse when a writeback has completed.

Behaviour:
- Storage:
  - Array of 2^LINE_ADDR_W x WORDS_PER_LINE words.
  - Preloaded at time 0: line i word 0 = i, all other words 0.
  - Not cleared by rst_n.
- Reset (async assert, sync release):
  - state = IDLE; req_ready = 1.
  - rdata_valid, rdata_last, wdata_ready, wr_ack = 0; rdata = 0.
  - Beat counter and latency counter = 0.
- States: IDLE, WAIT, RBURST, WBURST, WACK.
- IDLE:
  - req_ready = 1.
  - Handshake when req_valid && req_ready at a clock edge: latch req_write, req_line_addr and the start index.
  - If LATENCY > 0, go to WAIT with cnt = LATENCY-1. Otherwise go directly to RBURST or WBURST.
- Request rules:
  - req_ready = 0 in every state other than IDLE.
  - There is no request queue.
  - A new request can be accepted no earlier than the cycle after a burst or WACK completes.
- WAIT:
  - Lasts exactly LATENCY cycles; decrements cnt on each edge.
  - At cnt == 0, go to RBURST or WBURST.
  - rdata_valid and wdata_ready are 0 throughout.
- RBURST:
  - rdata_valid = 1; rdata = mem[line][idx].
  - Beat transfers on rdata_valid && rdata_ready; idx advances mod WORDS_PER_LINE.
  - rdata and rdata_last hold stable while rdata_ready = 0.
  - rdata_last = 1 on the 16th beat.
  - After the last beat transfers: go to IDLE; rdata_valid = 0 next cycle.
- WBURST:
  - wdata_ready = 1; idx always starts at 0.
  - On wdata_valid: write mem[line][idx] = wdata, then increment idx.
  - After the 16th write, go to WACK.
  - wdata_valid = 0 stalls the burst with no write.
- WACK:
  - wr_ack = 1 for exactly one cycle, then IDLE.
- Timing: with handshake at edge E0, the first rdata_valid or wdata_ready is visible after edge E0+LATENCY.
- Read-after-write: a fill of a line issued after its wr_ack returns the new data.
- Reset mid-operation: returns to IDLE immediately. Words already written in a partial writeback remain; no wr_ack is generated.
- Counter width is log2(WORDS_PER_LINE); idx wraps cleanly with no overflow flag.

Optional Feature:
- Macro: LINE_MEM_CRIT_WORD_FIRST_EN.
- Defined:
  - Read bursts start at idx = req_word (latched at handshake) and wrap mod 16.
  - rdata_last is asserted on the 16th beat, i.e. on word req_word-1 mod 16.
- Undefined:
  - req_word is ignored; reads always start at word 0.
- Writebacks start at 0 in both cases.

Decomposition:
- Package line_mem_pkg:
  - state enum line_mem_state_t (IDLE, WAIT, RBURST, WBURST, WACK);
  - constants WORDS_PER_LINE and BEAT_IDX_W;
  - typedef for the line address.
- Sub-module line_mem_array:
  - 1 async read port, 1 sync write port;
  - holds storage and preload.
- The FSM stays in line_mem_responder.

Test Plan:
- Fill line 8, LATENCY = 4, rdata_ready = 1:
  - first rdata_valid appears 4 cycles after the handshake edge;
  - beats are 8, 0 x15; rdata_last on beat 16; req_ready = 1 the following cycle.
- Writeback line 8 with beats 129..144 and wdata_valid gapped every 3rd cycle, then fill line 8:
  - wr_ack pulses once after the 16th accepted beat;
  - readback is 129..144.
- Fill line 1024 with rdata_ready toggling 1/0:
  - rdata is stable during stalls;
  - exactly 16 transfers: 1024, then 0s.
- With LINE_MEM_CRIT_WORD_FIRST_EN defined, fill line 8 with req_word = 9 after the writeback of 129..144:
  - beats are 138..144, then 129..137;
  - rdata_last on 137.
- Assert rst_n low after beat 5 of a writeback to line 3:
  - all outputs reset asynchronously; no wr_ack;
  - a subsequent fill of line 3 returns new words 0–4 and original words 5–15;
  - req_ready = 1 after release.
- LATENCY = 0 instance, fill line 0:
  - rdata_valid visible right after the handshake edge; data 0 x16.
